// File: rtl/sensor_alarm_multi.sv
// Multi-channel sensor alarm: per-channel hysteresis and debounce, 4-state alarm FSM, hottest-channel report.
// Optional macro SENSOR_ALARM_AUTOCLEAR_EN: ALARM auto-clears after CLR_TICKS consecutive quiet ticks.

module sensor_alarm_multi #(
    parameter int N_CH        = 4,
    parameter int TW          = 6,
    parameter int T_HI        = 40,
    parameter int T_HYST      = 3,
    parameter int DEB_CYC     = 4,
    parameter int ALERT_TICKS = 8,
    parameter int CLR_TICKS   = 16,
    localparam int CHW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               en,
    input  logic               ack,
    input  logic [N_CH*TW-1:0] temp,
    input  logic [N_CH-1:0]    mov,
    input  logic [N_CH-1:0]    pres,
    output logic [1:0]         estado,
    output logic               led_en,
    output logic               led_pelig,
    output logic               en_7,
    output logic [N_CH-1:0]    alarm_ch,
    output logic [TW-1:0]      disp_temp,
    output logic [CHW-1:0]     disp_ch
);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_ARMED = 2'b01,
        S_ALERT = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    localparam int DW         = $clog2(DEB_CYC + 1);
    localparam int AW         = (ALERT_TICKS > 1) ? $clog2(ALERT_TICKS) : 1;
    localparam int LO_INT     = T_HI - T_HYST;
    localparam int ALERT_LAST = ALERT_TICKS - 1;

    localparam logic [TW:0]   HI_V  = T_HI[TW:0];
    localparam logic [TW:0]   LO_V  = LO_INT[TW:0];
    localparam logic [DW-1:0] DEB_V = DEB_CYC[DW-1:0];
    localparam logic [AW-1:0] AL_V  = ALERT_LAST[AW-1:0];

    if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
        $error("sensor_alarm_multi: N_CH must be in 1..16");
    end
    if (T_HYST < 0 || T_HYST > T_HI || T_HI >= (1 << TW)) begin : g_chk_thr
        $error("sensor_alarm_multi: need 0 <= T_HYST <= T_HI < 2**TW");
    end
    if (DEB_CYC < 1 || ALERT_TICKS < 1 || CLR_TICKS < 1) begin : g_chk_cnt
        $error("sensor_alarm_multi: DEB_CYC, ALERT_TICKS and CLR_TICKS must be >= 1");
    end

    state_t              state, state_nx;
    logic [AW-1:0]       acnt, acnt_nx;
    logic [N_CH-1:0]     alarm_ch_nx;
    logic                pel_nx;
    logic                ack_l;
    logic                any_q;

    logic [N_CH-1:0]     hot, raw, qual;
    logic [DW-1:0]       deb_cnt [N_CH];
    logic [TW-1:0]       ch_temp [N_CH];
    logic [TW-1:0]       max_t;
    logic [CHW-1:0]      max_i;

`ifdef SENSOR_ALARM_AUTOCLEAR_EN
    localparam int CW      = (CLR_TICKS > 1) ? $clog2(CLR_TICKS) : 1;
    localparam int CLR_M1  = CLR_TICKS - 1;
    localparam logic [CW-1:0] CLR_V = CLR_M1[CW-1:0];
    logic [CW-1:0]       clr_cnt, clr_nx;
`endif

    assign estado = state;

    // raw danger sees the hot flag from the previous tick, not this tick's temperature
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_temp[i] = temp[i*TW +: TW];
            raw[i]     = hot[i] | (mov[i] & pres[i]);
            qual[i]    = (deb_cnt[i] == DEB_V);
        end
        any_q = |qual;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hot <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if ({1'b0, ch_temp[i]} >= HI_V) begin
                    hot[i] <= 1'b1;
                end else if ({1'b0, ch_temp[i]} < LO_V) begin
                    hot[i] <= 1'b0;
                end
                if (!raw[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DEB_V) begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Strict '>' keeps the lowest index on ties
    always_comb begin
        max_t = ch_temp[0];
        max_i = '0;
        for (int unsigned i = 1; i < N_CH; i++) begin
            if (ch_temp[i] > max_t) begin
                max_t = ch_temp[i];
                max_i = i[CHW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_temp <= '0;
            disp_ch   <= '0;
        end else if (tick) begin
            disp_temp <= max_t;
            disp_ch   <= max_i;
        end
    end

    // A tick-coincident ack is kept for the following tick's evaluation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_l <= 1'b0;
        end else if (ack) begin
            ack_l <= 1'b1;
        end else if (tick) begin
            ack_l <= 1'b0;
        end
    end

    always_comb begin
        state_nx    = state;
        acnt_nx     = acnt;
        alarm_ch_nx = alarm_ch;
        pel_nx      = led_pelig;
`ifdef SENSOR_ALARM_AUTOCLEAR_EN
        clr_nx      = '0;
`endif
        if (!en) begin
            state_nx = S_OFF;
        end else begin
            case (state)
                S_OFF: state_nx = S_ARMED;
                S_ARMED: begin
                    if (any_q) begin
                        state_nx = S_ALERT;
                        acnt_nx  = '0;
                    end
                end
                S_ALERT: begin
                    if (!any_q) begin
                        state_nx = S_ARMED;
                    end else if (acnt == AL_V) begin
                        state_nx = S_ALARM;
                    end else begin
                        acnt_nx = acnt + AW'(1);
                    end
                end
                S_ALARM: begin
                    if (ack_l && !any_q) begin
                        state_nx = S_ARMED;
                    end
`ifdef SENSOR_ALARM_AUTOCLEAR_EN
                    else if (!any_q) begin
                        if (clr_cnt == CLR_V) begin
                            state_nx = S_ARMED;
                        end else begin
                            clr_nx = clr_cnt + CW'(1);
                        end
                    end
`endif
                end
                default: state_nx = S_OFF;
            endcase
        end

        case (state_nx)
            S_ALERT: begin
                alarm_ch_nx = alarm_ch | qual;
                pel_nx      = (state == S_ALERT) ? ~led_pelig : 1'b1;
            end
            S_ALARM: begin
                alarm_ch_nx = (state == S_ALARM) ? alarm_ch : (alarm_ch | qual);
                pel_nx      = 1'b1;
            end
            default: begin
                alarm_ch_nx = '0;
                pel_nx      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_OFF;
            acnt      <= '0;
            alarm_ch  <= '0;
            led_pelig <= 1'b0;
            led_en    <= 1'b0;
            en_7      <= 1'b0;
`ifdef SENSOR_ALARM_AUTOCLEAR_EN
            clr_cnt   <= '0;
`endif
        end else if (tick) begin
            state     <= state_nx;
            acnt      <= acnt_nx;
            alarm_ch  <= alarm_ch_nx;
            led_pelig <= pel_nx;
            led_en    <= (state_nx != S_OFF);
            en_7      <= (state_nx != S_OFF);
`ifdef SENSOR_ALARM_AUTOCLEAR_EN
            clr_cnt   <= clr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sensor_alarm_multi.sv
// Self-checking bench for sensor_alarm_multi: directed vector table, async-reset sequence,
// then randomized stimulus against a behavioural model.

module tb_sensor_alarm_multi;

    localparam int N_CH        = 4;
    localparam int TW          = 6;
    localparam int T_HI        = 40;
    localparam int T_HYST      = 3;
    localparam int DEB_CYC     = 4;
    localparam int ALERT_TICKS = 8;
    localparam int CLR_TICKS   = 16;
`ifdef SENSOR_ALARM_AUTOCLEAR_EN
    localparam bit AC = 1'b1;
`else
    localparam bit AC = 1'b0;
`endif

    localparam int M_OFF = 0, M_ARMED = 1, M_ALERT = 2, M_ALARM = 3;

    logic        clk = 1'b0;
    logic        rst, tick, en, ack;
    logic [23:0] temp;
    logic [3:0]  mov, pres;
    logic [1:0]  estado;
    logic        led_en, led_pelig, en_7;
    logic [3:0]  alarm_ch;
    logic [5:0]  disp_temp;
    logic [1:0]  disp_ch;

    int n_cmp = 0;
    int n_bad = 0;

    sensor_alarm_multi #(
        .N_CH(N_CH), .TW(TW), .T_HI(T_HI), .T_HYST(T_HYST),
        .DEB_CYC(DEB_CYC), .ALERT_TICKS(ALERT_TICKS), .CLR_TICKS(CLR_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .ack(ack),
        .temp(temp), .mov(mov), .pres(pres),
        .estado(estado), .led_en(led_en), .led_pelig(led_pelig), .en_7(en_7),
        .alarm_ch(alarm_ch), .disp_temp(disp_temp), .disp_ch(disp_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int mask, input int pel,
                           input int dt, input int dc);
        chk({tag, " estado"},    int'(estado),    st);
        chk({tag, " led_en"},    int'(led_en),    int'(st != 0));
        chk({tag, " en_7"},      int'(en_7),      int'(st != 0));
        chk({tag, " alarm_ch"},  int'(alarm_ch),  mask);
        chk({tag, " led_pelig"}, int'(led_pelig), pel);
        chk({tag, " disp_temp"}, int'(disp_temp), dt);
        chk({tag, " disp_ch"},   int'(disp_ch),   dc);
    endtask

    // ---------------- behavioural reference model ----------------
    int mt [4];
    int m_state, m_age, m_clr, m_dt, m_dc;
    bit m_hot [4];
    int m_streak [4];
    bit m_ackp, m_pel;
    bit [3:0] m_mask;

    task automatic model_reset();
        m_state = M_OFF; m_age = 0; m_clr = 0; m_dt = 0; m_dc = 0;
        m_ackp = 0; m_pel = 0; m_mask = '0;
        for (int i = 0; i < 4; i++) begin
            m_hot[i] = 0;
            m_streak[i] = 0;
        end
    endtask

    task automatic model_step();
        bit [3:0] q;
        bit anyq;
        int ns;
        int best;
        if (!tick) begin
            m_ackp = m_ackp | ack;
            return;
        end
        for (int i = 0; i < 4; i++) q[i] = (m_streak[i] >= DEB_CYC);
        anyq = |q;
        for (int i = 0; i < 4; i++) begin
            if (m_hot[i] || (mov[i] && pres[i]))
                m_streak[i] = (m_streak[i] < 1000) ? m_streak[i] + 1 : 1000;
            else
                m_streak[i] = 0;
            if (mt[i] >= T_HI) m_hot[i] = 1;
            else if (mt[i] < T_HI - T_HYST) m_hot[i] = 0;
        end
        ns = m_state;
        if (!en) ns = M_OFF;
        else if (m_state == M_OFF) ns = M_ARMED;
        else if (m_state == M_ARMED) begin
            if (anyq) begin ns = M_ALERT; m_age = 0; end
        end else if (m_state == M_ALERT) begin
            if (!anyq) ns = M_ARMED;
            else begin
                m_age++;
                if (m_age >= ALERT_TICKS) ns = M_ALARM;
            end
        end else begin
            m_clr = anyq ? 0 : m_clr + 1;
            if (m_ackp && !anyq) ns = M_ARMED;
            else if (AC && m_clr >= CLR_TICKS) ns = M_ARMED;
        end
        if (ns == M_OFF || ns == M_ARMED) m_mask = '0;
        else if (!(m_state == M_ALARM && ns == M_ALARM)) m_mask = m_mask | q;
        if (ns == M_ALARM) m_pel = 1;
        else if (ns == M_ALERT) m_pel = (m_state == M_ALERT) ? !m_pel : 1'b1;
        else m_pel = 0;
        if (ns != M_ALARM) m_clr = 0;
        best = 0;
        for (int i = 1; i < 4; i++) if (mt[i] > mt[best]) best = i;
        m_dt = mt[best];
        m_dc = best;
        m_state = ns;
        m_ackp = ack;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit en; bit ack;
        int t0, t1, t2, t3;
        bit [3:0] mov; bit [3:0] pres;
        int cyc;
        int st; int mask; int pel; int dt; int dc;
    } vec_t;

    localparam int NV = 28;
    vec_t vt [NV];

    task automatic drive(input bit e, input bit a, input int t0, input int t1, input int t2,
                         input int t3, input bit [3:0] mv, input bit [3:0] pr);
        en = e; ack = a; mov = mv; pres = pr;
        mt[0] = t0; mt[1] = t1; mt[2] = t2; mt[3] = t3;
        temp = {mt[3][5:0], mt[2][5:0], mt[1][5:0], mt[0][5:0]};
    endtask

    initial begin
        //        en ack  t0  t1  t2  t3   mov     pres    cyc st  mask     pel         dt  dc
        vt[0]  = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   1,  1, 0,       0,          20, 0};
        vt[1]  = '{1, 0, 20, 20, 40, 20, 4'h0,   4'h0,   5,  1, 0,       0,          40, 2};
        vt[2]  = '{1, 0, 20, 20, 40, 20, 4'h0,   4'h0,   1,  2, 4'b0100, 1,          40, 2};
        vt[3]  = '{1, 0, 20, 20, 40, 20, 4'h0,   4'h0,   1,  2, 4'b0100, 0,          40, 2};
        vt[4]  = '{1, 0, 20, 20, 40, 20, 4'h0,   4'h0,   6,  2, 4'b0100, 0,          40, 2};
        vt[5]  = '{1, 0, 20, 20, 40, 20, 4'h0,   4'h0,   1,  3, 4'b0100, 1,          40, 2};
        vt[6]  = '{1, 0, 20, 20, 40, 20, 4'h0,   4'h0,   20, 3, 4'b0100, 1,          40, 2};
        vt[7]  = '{0, 0, 20, 20, 20, 20, 4'h0,   4'h0,   1,  0, 0,       0,          20, 0};
        vt[8]  = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   3,  1, 0,       0,          20, 0};
        vt[9]  = '{1, 0, 40, 20, 20, 20, 4'h0,   4'h0,   6,  2, 4'b0001, 1,          40, 0};
        vt[10] = '{1, 0, 38, 20, 20, 20, 4'h0,   4'h0,   3,  2, 4'b0001, 0,          38, 0};
        vt[11] = '{1, 0, 36, 20, 20, 20, 4'h0,   4'h0,   3,  1, 0,       0,          36, 0};
        vt[12] = '{1, 0, 20, 20, 20, 20, 4'b0010,4'b0010,4,  1, 0,       0,          20, 0};
        vt[13] = '{1, 0, 20, 20, 20, 20, 4'b0010,4'b0010,1,  2, 4'b0010, 1,          20, 0};
        vt[14] = '{1, 0, 20, 20, 20, 20, 4'b0010,4'b0010,8,  3, 4'b0010, 1,          20, 0};
        vt[15] = '{1, 1, 20, 20, 20, 20, 4'b0010,4'b0010,1,  3, 4'b0010, 1,          20, 0};
        vt[16] = '{1, 0, 20, 20, 20, 20, 4'b0010,4'b0010,1,  3, 4'b0010, 1,          20, 0};
        vt[17] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'b0010,1,  3, 4'b0010, 1,          20, 0};
        vt[18] = '{1, 1, 20, 20, 20, 20, 4'h0,   4'b0010,1,  3, 4'b0010, 1,          20, 0};
        vt[19] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'b0010,1,  1, 0,       0,          20, 0};
        vt[20] = '{1, 0, 20, 20, 20, 20, 4'b1000,4'b1000,3,  1, 0,       0,          20, 0};
        vt[21] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   3,  1, 0,       0,          20, 0};
        vt[22] = '{1, 0, 30, 35, 35, 10, 4'h0,   4'h0,   1,  1, 0,       0,          35, 1};
        vt[23] = '{1, 0, 20, 20, 45, 20, 4'h0,   4'h0,   14, 3, 4'b0100, 1,          45, 2};
        vt[24] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   2,  3, 4'b0100, 1,          20, 0};
        vt[25] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   15, 3, 4'b0100, 1,          20, 0};
        vt[26] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   1,  AC ? 1 : 3, AC ? 0 : 4, AC ? 0 : 1, 20, 0};
        vt[27] = '{1, 0, 20, 20, 20, 20, 4'h0,   4'h0,   30, AC ? 1 : 3, AC ? 0 : 4, AC ? 0 : 1, 20, 0};

        rst = 1'b1; tick = 1'b1;
        drive(0, 0, 20, 20, 20, 20, 4'h0, 4'h0);
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < NV; r++) begin
            drive(vt[r].en, vt[r].ack, vt[r].t0, vt[r].t1, vt[r].t2, vt[r].t3, vt[r].mov, vt[r].pres);
            repeat (vt[r].cyc) @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", r), vt[r].st, vt[r].mask, vt[r].pel, vt[r].dt, vt[r].dc);
        end

        // Async reset while in ALARM: outputs clear with no clock edge
        drive(1, 0, 20, 20, 40, 20, 4'h0, 4'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("pre-reset estado", int'(estado), 3);
        #3 rst = 1'b1;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // tick=0: nothing advances even with en asserted
        tick = 1'b0;
        drive(1, 0, 50, 20, 20, 20, 4'h0, 4'h0);
        repeat (5) @(posedge clk);
        #1;
        chk_all("no tick hold", 0, 0, 0, 0, 0);

        // Randomized run against the model
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        begin
            int hold = 0;
            for (int c = 0; c < 3000; c++) begin
                if (hold == 0) begin
                    drive(en, ack,
                          $urandom_range(20, 46), $urandom_range(20, 46),
                          $urandom_range(20, 46), $urandom_range(20, 46),
                          4'($urandom), 4'($urandom));
                    hold = $urandom_range(1, 12);
                end
                hold--;
                tick = ($urandom_range(0, 9) < 7);
                en   = ($urandom_range(0, 39) != 0);
                ack  = ($urandom_range(0, 14) == 0);
                model_step();
                @(posedge clk);
                #1;
                chk_all($sformatf("rand%0d", c), m_state, int'(m_mask), int'(m_pel), m_dt, m_dc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
